// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and a width-generic conditional two's-complement negate.
`default_nettype none

package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Widest value the negate helper handles; callers zero-extend in and truncate out,
  // which is exact modulo 2^n for any n <= MAX_W.
  localparam int MAX_W = 128;

  function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] v, input logic en);
    return en ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_step.sv
// One iteration of the shared engine: shift-add multiply or restoring divide
// over a 2*WIDTH accumulator, selected by div_mode.
`default_nettype none

module mult_div_step #(
  parameter int WIDTH = 32
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] upper;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    // Divide: remainder shifted left with the next dividend bit brought in.
    upper   = acc_in[2*WIDTH-1:WIDTH-1];
    trial   = upper - {1'b0, operand};
    acc_out = {sum, acc_in[WIDTH-1:1]};
    if (div_mode) begin
      if (!trial[WIDTH]) begin
        acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {upper[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply/divide unit driving HI/LO, with start/done
// handshake and a divide-by-zero pulse.
`default_nettype none

module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               dz;

  logic               op_div;
  logic               op_signed;
  logic               a_neg, b_neg;
  logic               zero_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign zero_div  = op_div && (b == '0);
  assign a_mag     = WIDTH'(neg_if(MAX_W'(a), a_neg));
  assign b_mag     = WIDTH'(neg_if(MAX_W'(b), b_neg));

  // neg_lo flags the product (multiply) or quotient (divide); neg_hi the remainder.
  assign prod_fix  = (2*WIDTH)'(neg_if(MAX_W'(acc), neg_lo));
  assign quot_fix  = WIDTH'(neg_if(MAX_W'(acc[WIDTH-1:0]), neg_lo));
  assign rem_fix   = WIDTH'(neg_if(MAX_W'(acc[2*WIDTH-1:WIDTH]), neg_hi));

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (is_div),
    .acc_in   (acc),
    .operand  (opnd),
    .acc_out  (acc_next)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = zero_div ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == '0) next_state = ST_FIX;
      ST_FIX:  next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && zero_div) begin
            dz <= 1'b1;
          end else if (start) begin
            acc    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
            opnd   <= op_div ? b_mag : a_mag;
            is_div <= op_div;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= op_div & a_neg;
            cnt    <= CW'(WIDTH - 1);
          end
        end
        ST_CALC: begin
          acc <= acc_next;
          cnt <= cnt - CW'(1);
        end
        ST_FIX: begin
          hi <= is_div ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
          lo <= is_div ? quot_fix : prod_fix[WIDTH-1:0];
        end
        default: dz <= 1'b0;
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign div_zero = dz;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// Randomised and directed checks of mult_div_unit against a latency/arithmetic model.
`default_nettype none

module tb_mult_div_unit;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int total = 0;
  int bad   = 0;
  bit en    = 1'b0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: begin p = 64'(sx * sy); return p; end
      2'b01: return ux * uy;
      2'b10: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
      default: begin p = ux / uy; q = longint'(ux % uy); return {q[31:0], p[31:0]}; end
    endcase
  endfunction

  // Cycle model: counts edges to completion instead of tracking states.
  int          m_left = 0;
  bit          m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;

  always @(posedge clock) begin
    if (!reset) begin
      m_left = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0;
    end else if (m_done) begin
      m_done = 0; m_dz = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        {m_hi, m_lo} = m_res;
      end
    end else if (start) begin
      if (op[1] && b == '0) begin
        m_done = 1; m_dz = 1;
      end else begin
        m_left = W + 1;
        m_res  = ref_result(op, a, b);
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (en) begin
      check("busy", 64'(busy), 64'(m_left > 0 || m_done));
      check("done", 64'(done), 64'(m_done));
      check("div_zero", 64'(div_zero), 64'(m_dz));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clock);
      k++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k;
    repeat (3) @(negedge clock);
    en = 1'b1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    reset = 1'b1;

    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(k);
    check("mult_latency", 64'(k), 64'(33));
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
    check("mult_dz", 64'(div_zero), 64'(0));

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(k);
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0001);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(k);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);

    issue(2'b11, 32'd7, 32'd2);
    wait_done(k);
    check("divu_lo", 64'(lo), 64'd3);
    check("divu_hi", 64'(hi), 64'd1);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(k);
    check("minneg1_lo", 64'(lo), 64'h8000_0000);
    check("minneg1_hi", 64'(hi), 64'h0);
    check("minneg1_dz", 64'(div_zero), 64'(0));

    issue(2'b11, 32'd100, 32'd0);
    wait_done(k);
    check("dz_latency", 64'(k), 64'(0));
    check("dz_flag", 64'(div_zero), 64'(1));
    check("dz_lo_kept", 64'(lo), 64'h8000_0000);
    check("dz_hi_kept", 64'(hi), 64'h0);

    issue(2'b00, 32'd5, 32'd9);
    repeat (5) @(negedge clock);
    start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd100;
    @(negedge clock);
    start = 1'b0;
    wait_done(k);
    check("ignore_lo", 64'(lo), 64'd45);
    check("ignore_hi", 64'(hi), 64'd0);

    issue(2'b00, 32'd1234, 32'd5678);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_hi", 64'(hi), 64'(0));
    check("midrst_lo", 64'(lo), 64'(0));
    issue(2'b00, 32'd6, 32'd7);
    wait_done(k);
    check("fresh_lo", 64'(lo), 64'd42);
    check("fresh_hi", 64'(hi), 64'd0);

    for (int i = 0; i < 8000; i++) begin
      @(negedge clock);
      start = ($urandom % 6 == 0);
      op    = 2'($urandom);
      a     = pick();
      b     = pick();
      reset = ($urandom % 3000 != 0);
    end
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;
    repeat (40) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
